// File: rtl/sr_drift_scheduler.sv
// Round-robin bounded random walk of per-harmonic omega_dt offsets sharing one LFSR/clamp datapath.
// Optional mean reversion toward zero is compiled in by defining SR_DRIFT_MEAN_REVERT_EN.
module sr_drift_scheduler #(
    parameter int          WIDTH         = 18,
    parameter int          NUM_HARMONICS = 5,
    parameter int          UPDATE_DIV    = 1024,
    parameter int          FAST_SIM      = 0,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clk_en,
    input  logic                           freeze,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    input  logic [2:0]                     cfg_idx,
    input  logic signed [WIDTH-1:0]        cfg_center,
    input  logic signed [WIDTH-1:0]        cfg_max,
    output logic [NUM_HARMONICS*WIDTH-1:0] omega_dt_packed,
    output logic [NUM_HARMONICS*WIDTH-1:0] drift_offset_packed,
    output logic                           busy,
    output logic                           pass_done
);

    localparam int              DIV       = (FAST_SIM != 0) ? 4 : UPDATE_DIV;
    localparam int              CW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   TICK_LAST = CW'(DIV - 1);
    localparam logic [2:0]      LAST_IDX  = 3'(NUM_HARMONICS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_STEP  = 2'd1,
        S_APPLY = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic signed [WIDTH-1:0] reset_center(input logic [2:0] g);
        logic signed [WIDTH-1:0] c;
        case (g)
            3'd0:    c = WIDTH'(16'd196);
            3'd1:    c = WIDTH'(16'd354);
            3'd2:    c = WIDTH'(16'd514);
            3'd3:    c = WIDTH'(16'd643);
            3'd4:    c = WIDTH'(16'd823);
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic signed [WIDTH-1:0] reset_bound(input logic [2:0] g);
        logic signed [WIDTH-1:0] b;
        case (g)
            3'd0:    b = WIDTH'(16'd23);
            3'd1:    b = WIDTH'(16'd28);
            3'd2:    b = WIDTH'(16'd39);
            3'd3:    b = WIDTH'(16'd58);
            3'd4:    b = WIDTH'(16'd77);
            default: b = '0;
        endcase
        return b;
    endfunction

    // Galois form of x^16+x^14+x^13+x^11+1, shifting toward bit 0
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    state_t                  state_r, state_s;
    logic [2:0]              idx_r, idx_s;
    logic [CW-1:0]           tick_r;
    logic                    pending_r;
    logic [15:0]             lfsr_r, lfsr_nx_s;
    logic [1:0]              code_r;
    logic                    busy_r, pass_done_r;
    logic signed [WIDTH-1:0] center_r [NUM_HARMONICS];
    logic signed [WIDTH-1:0] bound_r  [NUM_HARMONICS];
    logic signed [WIDTH-1:0] offset_r [NUM_HARMONICS];

    logic                    trigger_s, cfg_fire_s;
    logic signed [WIDTH-1:0] sel_off_s, sel_bnd_s, new_off_s, cfg_bnd_s;
    logic signed [WIDTH:0]   step_s, sum_s, lim_s;
`ifdef SR_DRIFT_MEAN_REVERT_EN
    logic signed [WIDTH:0]   off_ext_s, mag_s, half_s;
`endif

    assign trigger_s  = clk_en & ~freeze & (tick_r == TICK_LAST);
    assign cfg_ready  = (state_r == S_IDLE) & ~pending_r & ~trigger_s;
    assign cfg_fire_s = cfg_valid & cfg_ready;
    assign lfsr_nx_s  = lfsr_next(lfsr_r);
    assign cfg_bnd_s  = cfg_max[WIDTH-1] ? '0 : cfg_max;
    assign busy       = busy_r;
    assign pass_done  = pass_done_r;

    // Shared step/clamp datapath for the harmonic selected by idx_r
    always_comb begin
        sel_off_s = '0;
        sel_bnd_s = '0;
        for (int g = 0; g < NUM_HARMONICS; g++) begin
            sel_off_s = (idx_r == 3'(g)) ? offset_r[g] : sel_off_s;
            sel_bnd_s = (idx_r == 3'(g)) ? bound_r[g]  : sel_bnd_s;
        end
        case (code_r)
            2'b00:   step_s = {(WIDTH+1){1'b1}};
            2'b11:   step_s = (WIDTH+1)'(1'b1);
            default: step_s = '0;
        endcase
        lim_s = {1'b0, sel_bnd_s};
`ifdef SR_DRIFT_MEAN_REVERT_EN
        off_ext_s = {sel_off_s[WIDTH-1], sel_off_s};
        mag_s     = sel_off_s[WIDTH-1] ? -off_ext_s : off_ext_s;
        half_s    = lim_s >>> 1;
        if ((code_r == 2'b01) && (mag_s > half_s)) begin
            step_s = sel_off_s[WIDTH-1] ? (WIDTH+1)'(1'b1) : {(WIDTH+1){1'b1}};
        end else begin
            step_s = step_s;
        end
`endif
        sum_s = {sel_off_s[WIDTH-1], sel_off_s} + step_s;
        if (sum_s > lim_s) begin
            new_off_s = sel_bnd_s;
        end else if (sum_s < -lim_s) begin
            new_off_s = -sel_bnd_s;
        end else begin
            new_off_s = sum_s[WIDTH-1:0];
        end
    end

    // Pass sequencing: next state and harmonic index
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        case (state_r)
            S_IDLE: begin
                if (trigger_s || pending_r) begin
                    state_s = S_STEP;
                    idx_s   = '0;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_STEP:  state_s = S_APPLY;
            S_APPLY: begin
                if (idx_r == LAST_IDX) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_STEP;
                    idx_s   = idx_r + 3'd1;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: begin
                state_s = S_IDLE;
                idx_s   = '0;
            end
        endcase
    end

    // State register with status flags registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            idx_r       <= '0;
            busy_r      <= 1'b0;
            pass_done_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            busy_r      <= (state_s == S_STEP) || (state_s == S_APPLY);
            pass_done_r <= (state_s == S_DONE);
        end
    end

    // Update-rate divider and the single-deep pending-pass flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_r    <= '0;
            pending_r <= 1'b0;
        end else begin
            if (clk_en && !freeze) begin
                tick_r <= trigger_s ? '0 : tick_r + CW'(1'b1);
            end
            if ((state_r == S_IDLE) && (trigger_s || pending_r)) begin
                pending_r <= 1'b0;
            end else if (trigger_s) begin
                pending_r <= 1'b1;
            end
        end
    end

    // Random source advances once per harmonic; step code taken from the new value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= LFSR_SEED;
            code_r <= 2'b00;
        end else if (state_r == S_STEP) begin
            lfsr_r <= lfsr_nx_s;
            code_r <= lfsr_nx_s[1:0];
        end
    end

    // Per-harmonic centre/bound/offset storage; config only lands while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < NUM_HARMONICS; g++) begin
                center_r[g] <= reset_center(3'(g));
                bound_r[g]  <= reset_bound(3'(g));
                offset_r[g] <= '0;
            end
        end else begin
            for (int g = 0; g < NUM_HARMONICS; g++) begin
                if (cfg_fire_s && (cfg_idx == 3'(g))) begin
                    center_r[g] <= cfg_center;
                    bound_r[g]  <= cfg_bnd_s;
                    offset_r[g] <= '0;
                end else if ((state_r == S_APPLY) && (idx_r == 3'(g))) begin
                    offset_r[g] <= new_off_s;
                end
            end
        end
    end

    // Output packing straight from the registers
    always_comb begin
        omega_dt_packed     = '0;
        drift_offset_packed = '0;
        for (int g = 0; g < NUM_HARMONICS; g++) begin
            omega_dt_packed[g*WIDTH +: WIDTH]     = center_r[g] + offset_r[g];
            drift_offset_packed[g*WIDTH +: WIDTH] = offset_r[g];
        end
    end

endmodule

// File: tb/tb_sr_drift_scheduler.sv
// Self-checking bench for sr_drift_scheduler (FAST_SIM divider of 4) against a pass-level model.
module tb_sr_drift_scheduler;

    localparam int W = 18;
    localparam int N = 5;

    logic           clk = 1'b0;
    logic           rst_n, clk_en, freeze, cfg_valid, cfg_ready;
    logic [2:0]     cfg_idx;
    logic [W-1:0]   cfg_center, cfg_max;
    logic [N*W-1:0] omega_dt_packed, drift_offset_packed;
    logic           busy, pass_done;

    always #5 clk = ~clk;

    sr_drift_scheduler #(.WIDTH(W), .NUM_HARMONICS(N), .UPDATE_DIV(1024), .FAST_SIM(1),
                         .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .freeze(freeze),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
        .cfg_center(cfg_center), .cfg_max(cfg_max),
        .omega_dt_packed(omega_dt_packed), .drift_offset_packed(drift_offset_packed),
        .busy(busy), .pass_done(pass_done));

    int checks = 0;
    int failures = 0;
    int m_center[N];
    int m_bound[N];
    int m_off[N];
    int m_lfsr;
    int tm;
    int rst_c[N] = '{196, 354, 514, 643, 823};
    int rst_b[N] = '{23, 28, 39, 58, 77};

    typedef struct {
        int idx;
        int center;
        int mx;
        int chk_g;
        int exp_omega;
    } vec_t;
    vec_t vecs[6];

    initial begin
        #5000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int slice_s(input logic [N*W-1:0] v, input int g);
        logic signed [W-1:0] t;
        t = v[g*W +: W];
        return int'(t);
    endfunction

    function automatic int wrapw(input int x);
        logic signed [W-1:0] t;
        t = x[W-1:0];
        return int'(t);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < N; g++) begin
            m_center[g] = rst_c[g];
            m_bound[g]  = rst_b[g];
            m_off[g]    = 0;
        end
        m_lfsr = 'hACE1;
        tm     = 0;
    endtask

    // One full pass: each harmonic draws a fresh LFSR value and takes a clamped step
    task automatic model_pass();
        int code, step, n;
        for (int g = 0; g < N; g++) begin
            m_lfsr = (m_lfsr % 2 == 1) ? ((m_lfsr / 2) ^ 'hB400) : (m_lfsr / 2);
            code   = m_lfsr % 4;
            step   = (code == 0) ? -1 : ((code == 3) ? 1 : 0);
            n      = m_off[g] + step;
            if (n > m_bound[g]) n = m_bound[g];
            if (n < -m_bound[g]) n = -m_bound[g];
            m_off[g] = n;
        end
    endtask

    task automatic model_cfg(input int idx, input int c, input int mx);
        if (idx < N) begin
            m_center[idx] = wrapw(c);
            m_bound[idx]  = (mx < 0) ? 0 : mx;
            m_off[idx]    = 0;
        end
    endtask

    task automatic check_all();
        for (int g = 0; g < N; g++) begin
            chk($sformatf("offset[%0d]", g), slice_s(drift_offset_packed, g), m_off[g]);
            chk($sformatf("omega[%0d]", g), slice_s(omega_dt_packed, g), wrapw(m_center[g] + m_off[g]));
        end
    endtask

    task automatic cyc(input bit en, input bit frz);
        clk_en = en;
        freeze = frz;
        @(posedge clk);
        #1;
        if (en && !frz) tm = (tm + 1) % 4;
    endtask

    task automatic do_cfg(input int idx, input int c, input int mx);
        cfg_valid  = 1'b1;
        cfg_idx    = idx[2:0];
        cfg_center = c[W-1:0];
        cfg_max    = mx[W-1:0];
        clk_en     = 1'b0;
        #1;
        chk("cfg_ready_idle", cfg_ready, 1);
        cyc(0, 0);
        cfg_valid = 1'b0;
        model_cfg(idx, c, mx);
    endtask

    task automatic wait_done();
        bit got;
        got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            cyc(0, 0);
            if (pass_done) got = 1;
        end
        chk("pass_done_seen", got, 1);
    endtask

    task automatic run_pass(input bit rand_freeze);
        bit trig, frz;
        int guard;
        trig  = 0;
        guard = 0;
        while (!trig && guard < 200) begin
            frz  = rand_freeze ? ($urandom_range(0, 3) == 0) : 1'b0;
            trig = (!frz && tm == 3);
            cyc(1, frz);
            chk("busy_vs_trigger", busy, trig);
            guard++;
        end
        clk_en = 1'b0;
        freeze = 1'b0;
        wait_done();
        model_pass();
        check_all();
        cyc(0, 0);
        chk("post_pass_idle", busy | pass_done, 0);
    endtask

    task automatic apply_reset();
        clk_en    = 1'b0;
        freeze    = 1'b0;
        cfg_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    initial begin
        bit saw, inrange;
        int off2, passes, spent, mask, ndist;

        rst_n = 1'b0; clk_en = 1'b0; freeze = 1'b0; cfg_valid = 1'b0;
        cfg_idx = 3'd0; cfg_center = '0; cfg_max = '0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        model_reset();

        // reset state
        for (int g = 0; g < N; g++)
            chk($sformatf("reset_omega[%0d]", g), slice_s(omega_dt_packed, g), rst_c[g]);
        chk("reset_offsets", (drift_offset_packed == '0) ? 1 : 0, 1);
        chk("reset_busy", busy, 0);
        chk("reset_pass_done", pass_done, 0);
        chk("reset_cfg_ready", cfg_ready, 1);

        // table-driven configuration writes (offsets all zero here)
        vecs[0] = '{0, 100, 10, 0, 100};
        vecs[1] = '{4, -300, 5, 4, -300};
        vecs[2] = '{6, 999, 9, 3, 643};
        vecs[3] = '{1, 131000, 3, 1, 131000};
        vecs[4] = '{3, -131000, -5, 3, -131000};
        vecs[5] = '{7, 1, 1, 0, 100};
        for (int i = 0; i < 6; i++) begin
            do_cfg(vecs[i].idx, vecs[i].center, vecs[i].mx);
            chk($sformatf("vec%0d_omega", i), slice_s(omega_dt_packed, vecs[i].chk_g), vecs[i].exp_omega);
            chk($sformatf("vec%0d_offset", i), slice_s(drift_offset_packed, vecs[i].chk_g), 0);
        end

        // pass timing
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0);
            chk("timing_pre_busy", busy, 0);
        end
        clk_en = 1'b1;
        #1;
        chk("cfg_ready_on_trigger", cfg_ready, 0);
        cyc(1, 0);
        clk_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("timing_busy_t%0d", i), busy, 1);
            chk($sformatf("timing_no_done_t%0d", i), pass_done, 0);
            cyc(0, 0);
        end
        chk("timing_done_pulse", pass_done, 1);
        chk("timing_busy_low_at_done", busy, 0);
        model_pass();
        check_all();
        cyc(0, 0);
        chk("timing_done_one_cycle", pass_done, 0);
        chk("timing_idle_ready", cfg_ready, 1);

        // freeze holds the divider (101 is not a multiple of 4)
        saw = 0;
        for (int i = 0; i < 101; i++) begin
            cyc(1, 1);
            if (busy) saw = 1;
        end
        chk("freeze_no_busy", saw, 0);
        run_pass(0);

        // pending: two triggers during a pass, only one extra pass
        for (int i = 0; i < 4; i++) cyc(1, 0);
        chk("pend_t0_busy", busy, 1);
        for (int i = 1; i <= 8; i++) begin
            cyc(1, 0);
            chk($sformatf("pend_t%0d_busy", i), busy, 1);
        end
        cyc(0, 0);
        chk("pend_t9_busy", busy, 1);
        cyc(0, 0);
        chk("pend_t10_done", pass_done, 1);
        model_pass();
        check_all();
        cyc(0, 0);
        chk("pend_t11_idle", busy | pass_done, 0);
        chk("pend_t11_ready", cfg_ready, 0);
        cyc(0, 0);
        chk("pend_t12_restart", busy, 1);
        wait_done();
        model_pass();
        check_all();
        saw = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0);
            if (busy) saw = 1;
        end
        chk("pend_third_dropped", saw, 0);

        // config held across a pass; negative bound stores 0
        for (int i = 0; i < 4; i++) cyc(1, 0);
        clk_en = 1'b0;
        cfg_valid = 1'b1; cfg_idx = 3'd1; cfg_center = 18'sd1000; cfg_max = -18'sd5;
        #1;
        chk("hold_ready_busy", cfg_ready, 0);
        saw = 0;
        for (int k = 0; k < 40 && !saw; k++) begin
            cyc(0, 0);
            if (busy || pass_done) begin
                chk("hold_ready_busy", cfg_ready, 0);
                if (pass_done) begin
                    model_pass();
                    check_all();
                end
            end else begin
                saw = 1;
            end
        end
        chk("hold_reached_idle", saw, 1);
        chk("hold_ready_idle", cfg_ready, 1);
        cyc(0, 0);
        cfg_valid = 1'b0;
        model_cfg(1, 1000, -5);
        check_all();
        for (int i = 0; i < 3; i++) run_pass(0);

        // clamp: bound 2 on harmonic 2 with back-to-back passes
        do_cfg(2, 514, 2);
        passes = 0; spent = 0; mask = 0;
        while (passes < 2000 && spent < 40000) begin
            cyc(1, 0);
            spent++;
            off2 = slice_s(drift_offset_packed, 2);
            inrange = (off2 >= -2 && off2 <= 2);
            chk("clamp_range", inrange, 1);
            if (pass_done) begin
                model_pass();
                passes++;
                check_all();
                if (inrange) mask = mask | (1 << (off2 + 2));
            end
        end
        chk("clamp_passes", passes, 2000);
        ndist = $countones(mask);
        chk("clamp_distinct_ge3", (ndist >= 3) ? 1 : 0, 1);
        apply_reset();
        check_all();

        // randomized configuration and passes with random freeze gaps
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 2) == 0)
                do_cfg(int'($urandom_range(0, 7)), int'($urandom_range(0, 4000)) - 2000,
                       int'($urandom_range(0, 50)) - 8);
            run_pass(1);
        end

        // async reset during APPLY of harmonic 3
        for (int i = 0; i < 4; i++) cyc(1, 0);
        clk_en = 1'b0;
        chk("midrst_started", busy, 1);
        for (int i = 0; i < 7; i++) cyc(0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int g = 0; g < N; g++)
            chk($sformatf("midrst_omega[%0d]", g), slice_s(omega_dt_packed, g), rst_c[g]);
        chk("midrst_offsets", (drift_offset_packed == '0) ? 1 : 0, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", pass_done, 0);
        cyc(0, 0);
        cyc(0, 0);
        rst_n = 1'b1;
        saw = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0);
            if (pass_done || busy) saw = 1;
        end
        chk("midrst_no_pass_done", saw, 0);
        chk("midrst_ready", cfg_ready, 1);
        check_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
